// File: rtl/sha2_pkg.sv
// Shared SHA-256 constants, small-sigma functions and the schedule FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha2_pkg;

    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 512;
    localparam int NUM_ROUNDS = 64;
    localparam int WIN_WORDS  = 16;
    localparam int IDX_W      = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } sched_state_t;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63], one word per handshake.
// Latency: W[0] valid the cycle after the block handshake; 64 words then one idle cycle per block.
// Backpressure: data_out held stable while data_out_ready=0; no new block accepted until W[63] is taken.
module message_schedule
    import sha2_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               sync_rst,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    input  logic               data_in_last,
    output logic [WORD_W-1:0]  data_out,
    output logic [IDX_W-1:0]   data_out_index,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic               data_out_last,
    output logic               data_out_block_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_ROUNDS - 2);

    sched_state_t     state;
    sched_state_t     state_nxt;
    word_t            win [WIN_WORDS];
    logic [IDX_W-1:0] t;
    logic             last_q;
    logic             block_last_q;
    logic             in_fire;
    logic             out_fire;
    word_t            w_new;

    assign in_fire  = data_in_valid && data_in_ready;
    assign out_fire = data_out_valid && data_out_ready;

    // Next window word; the window slot w[0] is the word being emitted.
    assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    // State register; sync_rst overrides any handshake in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else if (sync_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept a block in IDLE, return after W[63] is consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire) state_nxt = EXPAND;
            EXPAND:  if (out_fire && t == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; the data_out_* group comes straight from registers.
    always_comb begin
        data_in_ready       = (state == IDLE);
        data_out_valid      = (state == EXPAND);
        data_out            = win[0];
        data_out_index      = t;
        data_out_block_last = block_last_q;
        data_out_last       = block_last_q && last_q;
    end

    // Window, round counter and framing flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < WIN_WORDS; i++) win[i] <= '0;
            t            <= '0;
            last_q       <= 1'b0;
            block_last_q <= 1'b0;
        end else if (sync_rst) begin
            for (int i = 0; i < WIN_WORDS; i++) win[i] <= '0;
            t            <= '0;
            last_q       <= 1'b0;
            block_last_q <= 1'b0;
        end else if (in_fire) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                win[i] <= data_in[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
            t            <= '0;
            last_q       <= data_in_last;
            block_last_q <= 1'b0;
        end else if (out_fire) begin
            if (t != LAST_IDX) begin
                for (int i = 0; i < WIN_WORDS - 1; i++) win[i] <= win[i+1];
                win[WIN_WORDS-1] <= w_new;
                t                <= t + 1'b1;
                block_last_q     <= (t == PENULT_IDX);
            end else begin
                // Window and index are left as-is; only the end-of-block flag drops.
                block_last_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_message_schedule.sv
module tb_message_schedule;

    logic         clk;
    logic         nrst;
    logic         sync_rst;
    logic [511:0] data_in;
    logic         data_in_valid;
    logic         data_in_ready;
    logic         data_in_last;
    logic [31:0]  data_out;
    logic [5:0]   data_out_index;
    logic         data_out_valid;
    logic         data_out_ready;
    logic         data_out_last;
    logic         data_out_block_last;

    int tests;
    int fails;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    logic [31:0] ref_w [64];

    message_schedule dut (
        .clk                 (clk),
        .nrst                (nrst),
        .sync_rst            (sync_rst),
        .data_in             (data_in),
        .data_in_valid       (data_in_valid),
        .data_in_ready       (data_in_ready),
        .data_in_last        (data_in_last),
        .data_out            (data_out),
        .data_out_index      (data_out_index),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready),
        .data_out_last       (data_out_last),
        .data_out_block_last (data_out_block_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook schedule recurrence over the full 64-entry array.
    task automatic model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(data_in_ready), 32'd1);
        chk({tag, "_valid"}, 32'(data_out_valid), 32'd0);
        chk({tag, "_data"}, data_out, 32'd0);
        chk({tag, "_index"}, 32'(data_out_index), 32'd0);
        chk({tag, "_last"}, 32'(data_out_last), 32'd0);
        chk({tag, "_blast"}, 32'(data_out_block_last), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after W[63] is taken.
    task automatic run_block(input logic [511:0] blk, input logic last, input bit bp);
        int t;
        int cyc;
        logic [31:0] pd;
        logic [5:0]  pi;
        bit held;
        model(blk);
        data_in       = blk;
        data_in_last  = last;
        data_in_valid = 1'b1;
        cyc = 0;
        while (data_in_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_delay", 32'(cyc), 32'd0);
        @(negedge clk);
        data_in_valid = 1'b0;
        t = 0;
        cyc = 0;
        held = 1'b0;
        pd = '0;
        pi = '0;
        while (t < 64 && cyc < 2000) begin
            chk("out_valid", 32'(data_out_valid), 32'd1);
            chk("in_ready_busy", 32'(data_in_ready), 32'd0);
            chk("word", data_out, exp_w[t]);
            chk("index", 32'(data_out_index), 32'(t));
            chk("block_last", 32'(data_out_block_last), 32'(t == 63));
            chk("msg_last", 32'(data_out_last), 32'(t == 63 && last));
            if (held) begin
                chk("hold_data", data_out, pd);
                chk("hold_index", 32'(data_out_index), 32'(pi));
            end
            data_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            got_w[t] = data_out;
            pd = data_out;
            pi = data_out_index;
            held = !data_out_ready;
            if (data_out_ready) t++;
            @(negedge clk);
            cyc++;
        end
        chk("words_done", 32'(t), 32'd64);
        data_out_ready = 1'b1;
    endtask

    // Starts a block and advances with ready high until index k is on the output.
    task automatic start_to_index(input logic [511:0] blk, input int k);
        int cyc;
        data_in       = blk;
        data_in_last  = 1'b1;
        data_in_valid = 1'b1;
        data_out_ready = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        cyc = 0;
        while (!(data_out_valid === 1'b1 && 32'(data_out_index) == k) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_index", 32'(data_out_index), 32'(k));
    endtask

    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;

    initial begin
        tests = 0;
        fails = 0;
        nrst = 1'b0;
        sync_rst = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        data_in_last = 1'b0;
        data_out_ready = 1'b1;
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        for (int i = 0; i < 16; i++) rnd_blk[511-32*i -: 32] = $urandom;

        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        // "abc" with ready held high
        run_block(abc_blk, 1'b1, 1'b0);
        chk("abc_w0", got_w[0], 32'h61626380);
        chk("abc_w15", got_w[15], 32'h00000018);
        chk("abc_w16", got_w[16], 32'h61626380);
        chk("abc_w17", got_w[17], 32'h000F0000);
        chk("abc_idle_ready", 32'(data_in_ready), 32'd1);
        chk("abc_idle_valid", 32'(data_out_valid), 32'd0);

        // All-zero block
        run_block('0, 1'b1, 1'b0);
        chk("zero_w63", got_w[63], 32'd0);
        chk("zero_idle_ready", 32'(data_in_ready), 32'd1);

        // Random block, ready high, then same block under backpressure
        run_block(rnd_blk, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) ref_w[i] = got_w[i];
        run_block(rnd_blk, 1'b0, 1'b1);
        for (int i = 0; i < 64; i += 9) chk("bp_same_seq", got_w[i], ref_w[i]);
        chk("bp_same_w63", got_w[63], ref_w[63]);

        // Back-to-back: last=0 then last=1
        run_block(rnd_blk, 1'b0, 1'b0);
        rnd_blk[31:0] = $urandom;
        run_block(rnd_blk, 1'b1, 1'b1);

        // sync_rst at index 20
        start_to_index(abc_blk, 20);
        sync_rst = 1'b1;
        @(negedge clk);
        sync_rst = 1'b0;
        chk_reset_outputs("sync_rst");
        run_block(abc_blk, 1'b1, 1'b0);
        chk("post_srst_w0", got_w[0], 32'h61626380);

        // nrst pulse mid-block, checked between clock edges
        start_to_index(rnd_blk, 5);
        #2;
        nrst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_async");
        run_block(rnd_blk, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
